// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, constants and address helpers for the data cache.
//   state_e        : controller FSM states
//   WORD_W, OFF_W  : word width and byte-offset bits
//   idx_of/tag_of  : split a byte address for a cache with idx_w index bits
package dcache_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    DONE
  } state_e;

  // Result is zero-extended; callers truncate to IDX_W bits.
  function automatic logic [WORD_W-1:0] idx_of(input logic [WORD_W-1:0] addr,
                                                input int unsigned      idx_w);
    return (addr >> OFF_W) & ((WORD_W'(1) << idx_w) - WORD_W'(1));
  endfunction

  // Result is zero-extended; callers truncate to WORD_W-IDX_W-OFF_W bits.
  function automatic logic [WORD_W-1:0] tag_of(input logic [WORD_W-1:0] addr,
                                                input int unsigned      idx_w);
    return addr >> (OFF_W + idx_w);
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: cache <-> data-memory req/ack bus.
//   mem_req_o   : request, held until mem_ack_i
//   mem_we_o    : 1 = write, 0 = read
//   mem_addr_o  : word-aligned address
//   mem_wdata_o : write data
//   mem_ack_i   : one-cycle completion pulse
//   mem_rdata_i : read data, valid with mem_ack_i
// master = cache controller, slave = memory.
interface dcache_ctrl_if;
  import dcache_pkg::*;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [WORD_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [WORD_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/dcache_array.sv
// dcache_array: LINES x {valid, tag, data} storage.
//   clk_i                : clock
//   clr_i                : synchronous clear of every valid bit (wins over a write)
//   rd_idx_i             : asynchronous read index
//   rd_valid_o/tag/data  : contents of line rd_idx_i
//   we_i, wr_idx_i,
//   wr_tag_i, wr_data_i  : synchronous write; sets the line valid
// Tag and data storage are not reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = WORD_W - IDX_W - OFF_W
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [WORD_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [WORD_W-1:0] wr_data_i
);

  localparam int unsigned LINES = 2 ** IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (clr_i)     valid_q           <= '0;
    else if (we_i) valid_q[wr_idx_i] <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   cpu_addr_i           : byte address from MEM stage ([1:0] ignored)
//   cpu_rd_i / cpu_wr_i  : load / store request, held while stall_o=1
//   cpu_wdata_i          : store data
//   cpu_rdata_o          : load data (same-cycle on hit, fill data in DONE)
//   stall_o              : pipeline freeze
//   inv_i                : invalidate all lines
//   mem                  : req/ack data-memory bus (master side)
//   hit_cnt_o/miss_cnt_o : saturating read hit/miss counters
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] cpu_addr_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              stall_o,
  input  logic              inv_i,
  dcache_ctrl_if.master     mem,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int unsigned TAG_W = WORD_W - IDX_W - OFF_W;

  state_e            state_q;
  logic [WORD_W-1:0] req_addr_q;
  logic [WORD_W-1:0] req_wdata_q;
  logic [WORD_W-1:0] fill_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic [WORD_W-1:0] look_addr;
  logic [IDX_W-1:0]  look_idx;
  logic [TAG_W-1:0]  look_tag;
  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [WORD_W-1:0] arr_data;
  logic              hit;
  logic              arr_we;

  // One lookup port serves both the CPU probe in IDLE and the
  // write-update hit check on the latched address while busy.
  assign look_addr = (state_q == IDLE) ? cpu_addr_i : req_addr_q;
  assign look_idx  = IDX_W'(idx_of(look_addr, IDX_W));
  assign look_tag  = TAG_W'(tag_of(look_addr, IDX_W));
  assign hit       = arr_valid && (arr_tag == look_tag);

  // Fill always writes; store ack writes only if the line still holds the
  // latched address. A coincident clear leaves the line invalid.
  assign arr_we = !rst_i && mem.mem_ack_i &&
                  ((state_q == RD_MISS) || ((state_q == WR_THRU) && hit));

  dcache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i      (clk_i),
    .clr_i      (rst_i | inv_i),
    .rd_idx_i   (look_idx),
    .rd_valid_o (arr_valid),
    .rd_tag_o   (arr_tag),
    .rd_data_o  (arr_data),
    .we_i       (arr_we),
    .wr_idx_i   (look_idx),
    .wr_tag_i   (look_tag),
    .wr_data_i  ((state_q == RD_MISS) ? mem.mem_rdata_i : req_wdata_q)
  );

  always_comb begin
    stall_o = 1'b0;
    unique case (state_q)
      IDLE:             stall_o = cpu_wr_i || (cpu_rd_i && !hit);
      RD_MISS, WR_THRU: stall_o = 1'b1;
      DONE:             stall_o = 1'b0;
      default:          stall_o = 1'b0;
    endcase
  end

  assign cpu_rdata_o     = (state_q == DONE) ? fill_q : arr_data;
  assign mem.mem_req_o   = mem_req_q;
  assign mem.mem_we_o    = mem_we_q;
  assign mem.mem_addr_o  = req_addr_q;
  assign mem.mem_wdata_o = req_wdata_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      fill_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_wr_i) begin
            req_addr_q  <= {cpu_addr_i[WORD_W-1:OFF_W], 2'b00};
            req_wdata_q <= cpu_wdata_i;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            state_q     <= WR_THRU;
          end else if (cpu_rd_i) begin
            if (hit) begin
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end else begin
              req_addr_q <= {cpu_addr_i[WORD_W-1:OFF_W], 2'b00};
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              state_q    <= RD_MISS;
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
          end
        end
        RD_MISS: begin
          if (mem.mem_ack_i) begin
            fill_q    <= mem.mem_rdata_i;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        WR_THRU: begin
          if (mem.mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
